gcd_unit: RTL
=============

GCD_UNIT -- requirements
Module: gcd_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, legal range 4..32.
REQ-002 SHALL have parameter MODE, default 0: 0 = repeated-subtraction Euclid; 1 = binary (Stein) algorithm.
REQ-003 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enter, input, 1: operand strobe, sampled at each rising clk.
REQ-006 SHALL have port in, input, WIDTH: operand value, valid while enter=1.
REQ-007 SHALL have port out, output, WIDTH: GCD result, valid while halt=1.
REQ-008 SHALL have port halt, output, 1: result valid, computation finished.
REQ-009 SHALL have port busy, output, 1: high in LOAD_Y and RUN.
REQ-010 SHALL have port steps, output, WIDTH: RUN-cycle count of the last or current computation, saturating at all-ones.

Function
REQ-011 SHALL implement a four-state FSM: IDLE, LOAD_Y, RUN, DONE.
REQ-012 IDLE: enter=1 SHALL capture in into X, clear steps and the shift count k, and go to LOAD_Y; enter=0 SHALL hold state.
REQ-013 LOAD_Y: enter=1 SHALL capture in into Y and go to RUN; enter=0 SHALL hold state.
REQ-014 RUN SHALL perform one step per cycle and increment steps, saturating, on every RUN cycle, including the final compare.
REQ-015 Step, MODE=0: X==Y -> DONE; X>Y -> X=X-Y; otherwise Y=Y-X.
REQ-016 Step, MODE=1, first matching rule only: X==Y -> DONE; X and Y both even -> both shift right 1, k+1; X even -> X shifts right 1; Y even -> Y shifts right 1; otherwise larger = larger - smaller.
REQ-017 Zero operands SHALL be handled in the first RUN cycle: X=0 -> out=Y; Y=0 -> out=X; both zero -> out=0; then go to DONE, steps=1.
REQ-018 On entry to DONE, out SHALL equal X (MODE=0) or X shifted left by k (MODE=1), and halt SHALL rise in that same cycle.
REQ-019 k SHALL be wide enough to count to WIDTH-1.
REQ-020 All arithmetic SHALL be unsigned, WIDTH bits, and never wrap: only larger minus smaller is computed.
REQ-021 DONE SHALL hold out, halt and steps until enter=1.
REQ-022 enter=1 in DONE SHALL capture in as the new X, clear halt, steps and k, and go to LOAD_Y.
REQ-023 enter SHALL be ignored during RUN.
REQ-024 A multi-cycle enter pulse SHALL cause one capture per state visited, i.e. level-sampled.

Reset
REQ-025 reset=1 SHALL, at the next rising clk and from any state including mid-RUN, set state=IDLE, X=Y=0, k=0, out=0, halt=0, busy=0, steps=0.
REQ-026 reset SHALL take priority over enter in the same cycle.

Structure
REQ-027 Package gcd_pkg SHALL hold the FSM state type (IDLE, LOAD_Y, RUN, DONE) and the MODE constants MODE_SUB=0 and MODE_BIN=1.
REQ-028 One combinational sub-module, gcd_step, SHALL compute next X, Y, k and the done flag from the current X, Y and k.
REQ-029 gcd_step SHALL be parameterised by WIDTH and MODE; gcd_unit SHALL hold all registers and the FSM.

Verification
REQ-030 MODE=0, WIDTH=8, X=12 then Y=18 -> halt after 3 RUN cycles, out=6, steps=3.
REQ-031 MODE=1, WIDTH=8, X=48 then Y=18 -> halt after 7 RUN cycles, out=6, steps=7.
REQ-032 MODE=0, X=255 then Y=1 -> out=1, steps=255; MODE=1, same inputs -> out=1 with steps < 20.
REQ-033 Zero operands: X=0, Y=35 -> out=35, steps=1; X=0, Y=0 -> out=0, halt=1.
REQ-034 Reset mid-RUN: reset asserted on 2nd RUN cycle of (12,18) -> next cycle all outputs 0, state IDLE; then (9,6) -> out=3.
REQ-035 Back-to-back: in DONE, enter with 100, then 75 -> halt drops on capture, out=25; randomized WIDTH=16 pairs compared against a software Euclid model.

Source files
------------

// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the GCD unit: the FSM state type with its four state
// constants, and the algorithm selector values for the MODE parameter.
// No ports (package).
// -----------------------------------------------------------------------------
package gcd_pkg;

    // Algorithm selectors for the MODE parameter
    localparam int MODE_SUB = 0;    // repeated-subtraction Euclid
    localparam int MODE_BIN = 1;    // binary (Stein) algorithm

    // FSM state type, kept as plain 2-bit constants for legacy tools
    typedef logic [1:0] state_t;

    localparam state_t IDLE   = 2'd0;
    localparam state_t LOAD_Y = 2'd1;
    localparam state_t RUN    = 2'd2;
    localparam state_t DONE   = 2'd3;

endpackage

// File: rtl/gcd_step.sv
// -----------------------------------------------------------------------------
// gcd_step
// Purely combinational single iteration of the GCD algorithm. Given the current
// operands and shift count it produces the next operands, the next shift count,
// a done flag and the final result to present when done is set.
//
// Ports:
//   x_i, y_i   : current operands (WIDTH bits, unsigned)
//   k_i        : current common power-of-two count (binary mode only)
//   x_o, y_o   : next operands
//   k_o        : next shift count
//   done_o     : high when this step finishes the computation
//   result_o   : GCD value, meaningful only while done_o is high
// -----------------------------------------------------------------------------
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_SUB,
    parameter int KW    = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic [KW-1:0]    k_i,
    output logic [WIDTH-1:0] x_o,
    output logic [WIDTH-1:0] y_o,
    output logic [KW-1:0]    k_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o
);

    // Rules are tried in priority order. A zero operand is caught before the
    // equality test so that subtraction never loops on a zero. Only the larger
    // operand ever has the smaller one subtracted from it, so nothing wraps.
    always_comb begin
        x_o      = x_i;
        y_o      = y_i;
        k_o      = k_i;
        done_o   = 1'b0;
        result_o = x_i;

        if (x_i == '0 || y_i == '0) begin
            // OR picks the non-zero operand, or zero when both are zero
            done_o   = 1'b1;
            result_o = x_i | y_i;
        end else if (x_i == y_i) begin
            done_o   = 1'b1;
            result_o = (MODE == MODE_BIN) ? (x_i << k_i) : x_i;
        end else if (MODE == MODE_BIN) begin
            if (!x_i[0] && !y_i[0]) begin
                // Common factor of two is pulled out and restored at the end
                x_o = x_i >> 1;
                y_o = y_i >> 1;
                k_o = k_i + KW'(1);
            end else if (!x_i[0]) begin
                x_o = x_i >> 1;
            end else if (!y_i[0]) begin
                y_o = y_i >> 1;
            end else if (x_i > y_i) begin
                x_o = x_i - y_i;
            end else begin
                y_o = y_i - x_i;
            end
        end else begin
            if (x_i > y_i) begin
                x_o = x_i - y_i;
            end else begin
                y_o = y_i - x_i;
            end
        end
    end

endmodule

// File: rtl/gcd_unit.sv
// -----------------------------------------------------------------------------
// gcd_unit
// Sequential GCD engine. Two operands are loaded through a single strobed port
// (X first, then Y), the iteration runs one step per clock, and the result is
// held with halt high until the next operand is strobed in.
//
// Ports:
//   clk    : sole clock, rising edge
//   reset  : synchronous active-high reset
//   enter  : operand strobe, level-sampled each rising edge
//   in     : operand value, valid while enter is high
//   out    : GCD result, valid while halt is high
//   halt   : result valid / computation finished
//   busy   : high while loading Y or running
//   steps  : number of RUN cycles of the last or current computation,
//            saturating at all-ones
// -----------------------------------------------------------------------------
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int MODE  = MODE_SUB
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enter,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             halt,
    output logic             busy,
    output logic [WIDTH-1:0] steps
);

    // Enough bits to count shifts up to WIDTH-1
    localparam int KW = $clog2(WIDTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] steps_q, steps_d;

    logic [WIDTH-1:0] stepX;
    logic [WIDTH-1:0] stepY;
    logic [KW-1:0]    stepK;
    logic             stepDone;
    logic [WIDTH-1:0] stepResult;

    gcd_step #(
        .WIDTH (WIDTH),
        .MODE  (MODE),
        .KW    (KW)
    ) u_step (
        .x_i      (x_q),
        .y_i      (y_q),
        .k_i      (k_q),
        .x_o      (stepX),
        .y_o      (stepY),
        .k_o      (stepK),
        .done_o   (stepDone),
        .result_o (stepResult)
    );

    // Next-state logic. A new X may be strobed in from IDLE or straight out of
    // DONE, which also drops halt because the state leaves DONE. Enter is not
    // looked at in RUN. The step counter counts every RUN cycle, including the
    // one that detects completion, and sticks at all-ones.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        k_d     = k_q;
        out_d   = out_q;
        steps_d = steps_q;

        case (state_q)
            IDLE, DONE: begin
                if (enter) begin
                    x_d     = in;
                    k_d     = '0;
                    steps_d = '0;
                    state_d = LOAD_Y;
                end
            end
            LOAD_Y: begin
                if (enter) begin
                    y_d     = in;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = stepX;
                y_d = stepY;
                k_d = stepK;
                if (steps_q != '1) begin
                    steps_d = steps_q + WIDTH'(1);
                end
                if (stepDone) begin
                    out_d   = stepResult;
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with synchronous reset taking priority over enter
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            k_q     <= '0;
            out_q   <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            k_q     <= k_d;
            out_q   <= out_d;
            steps_q <= steps_d;
        end
    end

    assign out   = out_q;
    assign steps = steps_q;
    assign halt  = (state_q == DONE);
    assign busy  = (state_q == LOAD_Y) || (state_q == RUN);

endmodule
